// File: rtl/draw_addr_sequencer_pkg.sv
// Shared types and default widths for the draw address-pair sequencer.
package draw_pkg;
    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned CNT_W_DEF  = 14;
    localparam int unsigned NUM_REQ    = 2;

    typedef logic req_id_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} draw_seq_state_t;
endpackage

// File: rtl/draw_addr_sequencer_if.sv
// Job request and framebuffer write-side bundle for draw_addr_sequencer.
interface draw_addr_sequencer_if #(
    parameter int unsigned ADDR_W = draw_pkg::ADDR_W_DEF,
    parameter int unsigned CNT_W  = draw_pkg::CNT_W_DEF
);
    logic [draw_pkg::NUM_REQ-1:0]             req_valid;
    logic [draw_pkg::NUM_REQ-1:0][ADDR_W-2:0] req_start;
    logic [draw_pkg::NUM_REQ-1:0][CNT_W-1:0]  req_count;
    logic [draw_pkg::NUM_REQ-1:0]             req_ready;
    logic                                     wr_valid;
    logic                                     wr_ready;
    logic [ADDR_W-1:0]                        Q_a;
    logic [ADDR_W-1:0]                        Q_b;
    logic                                     busy;
    logic                                     done;
    draw_pkg::req_id_t                        done_id;

    modport slave (
        input  req_valid, req_start, req_count, wr_ready,
        output req_ready, wr_valid, Q_a, Q_b, busy, done, done_id
    );

    modport master (
        output req_valid, req_start, req_count, wr_ready,
        input  req_ready, wr_valid, Q_a, Q_b, busy, done, done_id
    );
endinterface

// File: rtl/draw_addr_sequencer_rr_arbiter.sv
// Two-way round-robin arbiter; priority flips to the other requester after each grant.
module draw_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio;

    always_comb begin
        grant = 2'b00;
        if (prio == 1'b0) begin
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
        end else begin
            if (req[1])      grant = 2'b10;
            else if (req[0]) grant = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (advance && (|grant)) begin
            prio <= grant[0];
        end
    end
endmodule

// File: rtl/draw_addr_sequencer.sv
// Arbitrates two line jobs and sweeps the winner as even/odd framebuffer address pairs.
// Optional build macro: DRAW_SEQ_ABORT_EN adds an abort input that ends a running job early.
module draw_addr_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
`ifdef DRAW_SEQ_ABORT_EN
    input  logic abort,
`endif
    draw_addr_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    draw_seq_state_t   state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    req_id_t           owner, owner_n;
    req_id_t           sel;
    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              abort_req;

`ifdef DRAW_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Requests are only visible to the arbiter while idle, so nothing is accepted in RUN/DONE.
    assign arb_req = (state == IDLE) ? bus.req_valid : 2'b00;

    draw_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (state == IDLE),
        .grant   (grant)
    );

    assign bus.req_ready = grant;
    assign sel           = grant[1];

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        remaining_n = remaining;
        owner_n     = owner;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    idx_n       = bus.req_start[sel];
                    remaining_n = bus.req_count[sel];
                    owner_n     = sel;
                    state_n     = (bus.req_count[sel] == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // The index never wraps: a handshake at all-ones closes the job.
                if (bus.wr_ready) begin
                    idx_n       = (idx == IDX_MAX) ? idx : idx + IDX_W'(1);
                    remaining_n = remaining - CNT_W'(1);
                    if ((remaining == CNT_W'(1)) || (idx == IDX_MAX)) state_n = DONE;
                end
                if (abort_req) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            remaining    <= '0;
            owner        <= 1'b0;
            bus.wr_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.done_id  <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            remaining    <= remaining_n;
            owner        <= owner_n;
            bus.wr_valid <= (state_n == RUN);
            bus.busy     <= (state_n != IDLE);
            bus.done     <= (state_n == DONE);
            bus.done_id  <= owner_n;
        end
    end

    assign bus.Q_a = {idx, 1'b0};
    assign bus.Q_b = {idx, 1'b1};
endmodule

// File: tb/tb_draw_addr_sequencer.sv
// Directed self-checking bench for draw_addr_sequencer.
module tb_draw_addr_sequencer;
    logic clk;
    logic reset;
`ifdef DRAW_SEQ_ABORT_EN
    logic abort;
`endif
    int checks;
    int passes;

    draw_addr_sequencer_if #(.ADDR_W(14), .CNT_W(14)) bus ();

    draw_addr_sequencer #(.ADDR_W(14), .CNT_W(14)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DRAW_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 2 time units after each rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (bus.wr_valid !== 1'b0) $display("FAIL reset_wr_valid got %b want 0", bus.wr_valid); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passes++;
        checks++; if (bus.done_id !== 1'b0) $display("FAIL reset_done_id got %b want 0", bus.done_id); else passes++;
        checks++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", bus.req_ready); else passes++;
        checks++; if (bus.Q_a !== 14'd0) $display("FAIL reset_q_a got %0d want 0", bus.Q_a); else passes++;
        checks++; if (bus.Q_b !== 14'd1) $display("FAIL reset_q_b got %0d want 1", bus.Q_b); else passes++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        bus.req_valid    = 2'b01;
        bus.req_start[0] = 13'd1408;
        bus.req_count[0] = 14'd64;
        bus.wr_ready     = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) $display("FAIL single_req_ready got %b want 01", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'(2816 + 2*i) || bus.Q_b !== 14'(2817 + 2*i))
                $display("FAIL single_pair%0d got v=%b a=%0d b=%0d want v=1 a=%0d b=%0d",
                         i, bus.wr_valid, bus.Q_a, bus.Q_b, 2816 + 2*i, 2817 + 2*i);
            else passes++;
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b0 || bus.wr_valid !== 1'b0)
            $display("FAIL single_done got done=%b id=%b v=%b want 1 0 0", bus.done, bus.done_id, bus.wr_valid);
        else passes++;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL single_idle got done=%b busy=%b want 0 0", bus.done, bus.busy);
        else passes++;
    endtask

    task automatic test_contention();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        bus.req_valid    = 2'b11;
        bus.req_start[0] = 13'd0;
        bus.req_count[0] = 14'd4;
        bus.req_start[1] = 13'd100;
        bus.req_count[1] = 14'd2;
        bus.wr_ready     = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) $display("FAIL cont_first_grant got %b want 01", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 2'b10;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'(2*i) || bus.req_ready !== 2'b00)
                $display("FAIL cont_r0_pair%0d got v=%b a=%0d rdy=%b want v=1 a=%0d rdy=00",
                         i, bus.wr_valid, bus.Q_a, bus.req_ready, 2*i);
            else passes++;
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b0 || bus.req_ready !== 2'b00)
            $display("FAIL cont_done0 got done=%b id=%b rdy=%b want 1 0 00", bus.done, bus.done_id, bus.req_ready);
        else passes++;
        tick();
        checks++; if (bus.req_ready !== 2'b10) $display("FAIL cont_second_grant got %b want 10", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'(200 + 2*i) || bus.Q_b !== 14'(201 + 2*i))
                $display("FAIL cont_r1_pair%0d got v=%b a=%0d b=%0d want v=1 a=%0d b=%0d",
                         i, bus.wr_valid, bus.Q_a, bus.Q_b, 200 + 2*i, 201 + 2*i);
            else passes++;
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b1)
            $display("FAIL cont_done1 got done=%b id=%b want 1 1", bus.done, bus.done_id);
        else passes++;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [4:0] rdy_seq;
        int         exp_a [5];
        int         hs;
        rdy_seq = 5'b11001;
        exp_a   = '{20, 22, 22, 22, 24};
        hs      = 0;
        bus.req_valid    = 2'b01;
        bus.req_start[0] = 13'd10;
        bus.req_count[0] = 14'd3;
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            bus.wr_ready = rdy_seq[i];
            checks++;
            if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'(exp_a[i]) || bus.done !== 1'b0)
                $display("FAIL bp_cycle%0d got v=%b a=%0d done=%b want v=1 a=%0d done=0",
                         i, bus.wr_valid, bus.Q_a, bus.done, exp_a[i]);
            else passes++;
            if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) hs++;
            tick();
        end
        bus.wr_ready = 1'b1;
        checks++;
        if (bus.done !== 1'b1 || bus.wr_valid !== 1'b0 || hs != 3)
            $display("FAIL bp_done got done=%b v=%b handshakes=%0d want 1 0 3", bus.done, bus.wr_valid, hs);
        else passes++;
        tick();
    endtask

    task automatic test_saturation();
        bus.req_valid    = 2'b10;
        bus.req_start[1] = 13'd8190;
        bus.req_count[1] = 14'd10;
        bus.wr_ready     = 1'b1;
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'd16380 || bus.Q_b !== 14'd16381)
            $display("FAIL sat_pair0 got v=%b a=%0d b=%0d want 1 16380 16381", bus.wr_valid, bus.Q_a, bus.Q_b);
        else passes++;
        tick();
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'd16382 || bus.Q_b !== 14'd16383)
            $display("FAIL sat_pair1 got v=%b a=%0d b=%0d want 1 16382 16383", bus.wr_valid, bus.Q_a, bus.Q_b);
        else passes++;
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.wr_valid !== 1'b0 || bus.done_id !== 1'b1)
            $display("FAIL sat_done got done=%b v=%b id=%b want 1 0 1", bus.done, bus.wr_valid, bus.done_id);
        else passes++;
        tick();
    endtask

    task automatic test_zero_count();
        bus.req_valid    = 2'b01;
        bus.req_start[0] = 13'd500;
        bus.req_count[0] = 14'd0;
        #1;
        checks++; if (bus.req_ready !== 2'b01) $display("FAIL zero_req_ready got %b want 01", bus.req_ready); else passes++;
        tick();
        bus.req_valid = 2'b00;
        checks++;
        if (bus.done !== 1'b1 || bus.wr_valid !== 1'b0 || bus.done_id !== 1'b0)
            $display("FAIL zero_done got done=%b v=%b id=%b want 1 0 0", bus.done, bus.wr_valid, bus.done_id);
        else passes++;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_valid !== 1'b0)
            $display("FAIL zero_idle got busy=%b done=%b v=%b want 0 0 0", bus.busy, bus.done, bus.wr_valid);
        else passes++;
    endtask

    task automatic test_reset_mid_job();
        int done_seen;
        done_seen = 0;
        bus.req_valid    = 2'b01;
        bus.req_start[0] = 13'd300;
        bus.req_count[0] = 14'd50;
        bus.wr_ready     = 1'b1;
        tick();
        bus.req_valid = 2'b00;
        repeat (10) tick();
        checks++; if (bus.busy !== 1'b1) $display("FAIL rst_mid_running got busy=%b want 1", bus.busy); else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.wr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Q_a !== 14'd0 || bus.Q_b !== 14'd1)
            $display("FAIL rst_mid_values got v=%b busy=%b done=%b a=%0d b=%0d want 0 0 0 0 1",
                     bus.wr_valid, bus.busy, bus.done, bus.Q_a, bus.Q_b);
        else passes++;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.done === 1'b1 || bus.wr_valid === 1'b1) done_seen++;
            tick();
        end
        checks++; if (done_seen != 0) $display("FAIL rst_mid_no_done got %0d active cycles want 0", done_seen); else passes++;
    endtask

`ifdef DRAW_SEQ_ABORT_EN
    task automatic test_abort();
        int hs;
        hs = 0;
        abort = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) $display("FAIL abort_idle got busy=%b want 0", bus.busy); else passes++;
        abort = 1'b0;
        bus.req_valid    = 2'b10;
        bus.req_start[1] = 13'd40;
        bus.req_count[1] = 14'd10;
        bus.wr_ready     = 1'b1;
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                abort        = 1'b1;
                bus.wr_ready = 1'b0;
            end
            checks++;
            if (bus.wr_valid !== 1'b1 || bus.Q_a !== 14'(80 + 2*i))
                $display("FAIL abort_pair%0d got v=%b a=%0d want 1 %0d", i, bus.wr_valid, bus.Q_a, 80 + 2*i);
            else passes++;
            if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) hs++;
            tick();
        end
        abort        = 1'b0;
        bus.wr_ready = 1'b1;
        checks++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b1 || bus.wr_valid !== 1'b0 || hs != 4)
            $display("FAIL abort_done got done=%b id=%b v=%b handshakes=%0d want 1 1 0 4",
                     bus.done, bus.done_id, bus.wr_valid, hs);
        else passes++;
        tick();
    endtask
`endif

    initial begin
        checks        = 0;
        passes        = 0;
        reset         = 1'b0;
`ifdef DRAW_SEQ_ABORT_EN
        abort         = 1'b0;
`endif
        bus.req_valid = 2'b00;
        bus.req_start = '0;
        bus.req_count = '0;
        bus.wr_ready  = 1'b0;

        test_reset();
        test_single_job();
        test_contention();
        test_back_pressure();
        test_saturation();
        test_zero_count();
        test_reset_mid_job();
`ifdef DRAW_SEQ_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/draw_addr_sequencer.md
# draw_addr_sequencer

Sequences framebuffer address-pair generation for the draw path. Two requesters submit line jobs (start pair index plus pair count), and a round-robin arbiter grants one job at a time. The granted job is swept as even/odd address pairs toward the dual-port framebuffer write side, with downstream back-pressure. The block sits between the draw command sources and the framebuffer write port, replacing fixed-range address counters.

## Interface
- `ADDR_W`, 14: framebuffer byte-address width; the pair index is `ADDR_W-1` bits.
- `CNT_W`, 14: job pair-count width; must satisfy `CNT_W >= ADDR_W`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 2: job request, one bit per requester.
- `req_start` in 2x(`ADDR_W-1`): start pair index per requester.
- `req_count` in 2x`CNT_W`: number of pairs per requester.
- `req_ready` out 2: job accepted this cycle; one-hot or zero.
- `wr_valid` out 1: address pair valid.
- `wr_ready` in 1: framebuffer accepts the pair.
- `Q_a` out `ADDR_W`: even address `{idx,1'b0}`.
- `Q_b` out `ADDR_W`: odd address `{idx,1'b1}`.
- `busy` out 1: a job is in progress (state other than IDLE).
- `done` out 1: one-cycle pulse when a job completes.
- `done_id` out 1: requester that owned the completed job.
- `abort` in 1: present only with `DRAW_SEQ_ABORT_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:** the arbiter picks among asserted `req_valid` bits. `req_ready[g]` is driven combinationally for the granted requester `g`. On acceptance the block latches `idx=req_start[g]`, `remaining=req_count[g]` and `owner=g`, then:
  - goes to RUN if the count is nonzero;
  - goes to DONE if the count is 0, with no `wr_valid` issued.
- **Arbitration:** round-robin. After reset requester 0 has priority. After a grant the other requester has priority. With a single request pending, that requester is granted immediately.
- **RUN:** `wr_valid=1`, and `Q_a`/`Q_b` are derived from `idx`. On `wr_valid&&wr_ready`:
  - `idx` increments and `remaining` decrements;
  - when `remaining` reaches 1 at the handshake, the next state is DONE.
  - Without `wr_ready`, all outputs hold stable.
- **Wrap rule:** `idx` saturates at all-ones (8191 at default width). A handshake at the saturated index ends the job regardless of `remaining`, so no address wrap-around is ever emitted.
- **DONE:** `done=1` and `done_id=owner` for exactly one cycle, then IDLE. No request is accepted in DONE.
- **Reset values:** state IDLE; `idx=0`, `remaining=0`; `wr_valid=0`, `busy=0`, `done=0`, `done_id=0`, `req_ready=0`; `Q_a=0`, `Q_b=1`; arbiter priority points to requester 0.
- **Reset mid-job:** the job is dropped silently with no `done` pulse.

## Timing
- Job accepted at edge T (`req_ready` high in cycle T). The first `wr_valid` is in cycle T+1.
- N pairs with `wr_ready` tied high: `wr_valid` in cycles T+1..T+N, `done` in T+N+1, IDLE in T+N+2, so the next acceptance is earliest in T+N+2.
- Zero-count job: `done` in T+1.
- `Q_a`, `Q_b`, `wr_valid`, `busy`, `done` and `done_id` are all registered outputs. `req_ready` is combinational from the state and `req_valid`.

## Configuration
- `DRAW_SEQ_ABORT_EN` defined: adds the `abort` input.
  - `abort` high in RUN: the block goes to DONE on the next edge, pulses `done`/`done_id` normally, and does not issue the pending pair.
  - `abort` in IDLE or DONE has no effect.
  - `abort` wins over a simultaneous final handshake: that pair counts as transferred, and the block goes to DONE either way.
- `DRAW_SEQ_ABORT_EN` undefined: there is no `abort` port, and jobs always run to count or saturation.

## Structure
- Package `draw_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} draw_seq_state_t`;
  - `localparam` default `ADDR_W`/`CNT_W`;
  - the requester-id typedef.
- Sub-module `draw_rr_arbiter`: 2-way round-robin with inputs `req`/`advance` and outputs one-hot `grant`, holding the priority register. It is instantiated once.

## Test plan
- **Single job:** requester 0, start=1408, count=64, `wr_ready`=1 → pairs 2816/2817 through 2942/2943 in 64 consecutive cycles, then `done`=1 with `done_id`=0.
- **Contention:** both requesters valid in the same cycle after reset (start 0/count 4, start 100/count 2) → requester 0 granted first (addresses 0..7), then requester 1 (200..203), then `done_id` sequence 0,1.
- **Back-pressure:** count=3 with `wr_ready` toggling 1,0,0,1,1 → `Q_a` holds during the stalls, exactly 3 handshakes occur, `done` follows the third.
- **Saturation:** start=8190, count=10 → pairs 16380/16381 and 16382/16383 only, then `done`.
- **Zero count:** count=0 → no `wr_valid`, `done` in the cycle after acceptance.
- **Reset and abort:**
  - Reset asserted mid-RUN of a count=50 job → outputs go to reset values immediately and no `done` pulse occurs.
  - With `DRAW_SEQ_ABORT_EN`, `abort` at the 5th pair → `done` in the next cycle after exactly 4 handshakes.
